// File: rtl/ldmx_axil_pkg.sv
// Shared AXI4-Lite definitions for the LDMX register-access blocks:
// response codes, the command-master state encoding and counter width.
package ldmx_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_DATA,
      RESP
   } state_t;

endpackage

// File: rtl/axil_cmd_master_if.sv
// Bundle of the command/response stream and the AXI4-Lite master/slave
// channels of axil_cmd_master, with one modport per side.
interface axil_cmd_master_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout;
   logic [15:0] timeout_count;

   logic [31:0] axilReadMaster_araddr;
   logic [2:0]  axilReadMaster_arprot;
   logic        axilReadMaster_arvalid;
   logic        axilReadMaster_rready;
   logic        axilReadSlave_arready;
   logic [31:0] axilReadSlave_rdata;
   logic [1:0]  axilReadSlave_rresp;
   logic        axilReadSlave_rvalid;

   logic [31:0] axilWriteMaster_awaddr;
   logic [2:0]  axilWriteMaster_awprot;
   logic        axilWriteMaster_awvalid;
   logic [31:0] axilWriteMaster_wdata;
   logic [3:0]  axilWriteMaster_wstrb;
   logic        axilWriteMaster_wvalid;
   logic        axilWriteMaster_bready;
   logic        axilWriteSlave_awready;
   logic        axilWriteSlave_wready;
   logic [1:0]  axilWriteSlave_bresp;
   logic        axilWriteSlave_bvalid;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, timeout_count,
      output axilReadMaster_araddr, axilReadMaster_arprot, axilReadMaster_arvalid,
             axilReadMaster_rready,
      input  axilReadSlave_arready, axilReadSlave_rdata, axilReadSlave_rresp,
             axilReadSlave_rvalid,
      output axilWriteMaster_awaddr, axilWriteMaster_awprot, axilWriteMaster_awvalid,
             axilWriteMaster_wdata, axilWriteMaster_wstrb, axilWriteMaster_wvalid,
             axilWriteMaster_bready,
      input  axilWriteSlave_awready, axilWriteSlave_wready, axilWriteSlave_bresp,
             axilWriteSlave_bvalid
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, timeout_count,
      input  axilReadMaster_araddr, axilReadMaster_arprot, axilReadMaster_arvalid,
             axilReadMaster_rready,
      output axilReadSlave_arready, axilReadSlave_rdata, axilReadSlave_rresp,
             axilReadSlave_rvalid,
      input  axilWriteMaster_awaddr, axilWriteMaster_awprot, axilWriteMaster_awvalid,
             axilWriteMaster_wdata, axilWriteMaster_wstrb, axilWriteMaster_wvalid,
             axilWriteMaster_bready,
      output axilWriteSlave_awready, axilWriteSlave_wready, axilWriteSlave_bresp,
             axilWriteSlave_bvalid
   );

endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction,
// exactly one response out (a bus timeout guarantees the response).
module axil_cmd_master
   import ldmx_axil_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1023,
   parameter logic [2:0]  AXI_PROT       = 3'b000
) (
   input  logic        axilClk,
   input  logic        axilRst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic        rsp_timeout,
   output logic [15:0] timeout_count,
   output logic [31:0] axilReadMaster_araddr,
   output logic [2:0]  axilReadMaster_arprot,
   output logic        axilReadMaster_arvalid,
   output logic        axilReadMaster_rready,
   input  logic        axilReadSlave_arready,
   input  logic [31:0] axilReadSlave_rdata,
   input  logic [1:0]  axilReadSlave_rresp,
   input  logic        axilReadSlave_rvalid,
   output logic [31:0] axilWriteMaster_awaddr,
   output logic [2:0]  axilWriteMaster_awprot,
   output logic        axilWriteMaster_awvalid,
   output logic [31:0] axilWriteMaster_wdata,
   output logic [3:0]  axilWriteMaster_wstrb,
   output logic        axilWriteMaster_wvalid,
   output logic        axilWriteMaster_bready,
   input  logic        axilWriteSlave_awready,
   input  logic        axilWriteSlave_wready,
   input  logic [1:0]  axilWriteSlave_bresp,
   input  logic        axilWriteSlave_bvalid
);

   localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [CNT_W-1:0]   tcount_q, tcount_d;
   logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]         wstrb_q, wstrb_d;
   logic [1:0]         resp_q, resp_d;
   logic               awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
   logic               bready_q, bready_d, rready_q, rready_d;
   logic               rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
   logic               busy, done, timeout_hit;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tcount_d      = tcount_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      rdata_d       = rdata_q;
      resp_d        = resp_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      arvalid_d     = arvalid_q;
      bready_d      = bready_q;
      rready_d      = rready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_timeout_d = rsp_timeout_q;
      cnt_inc       = cnt_q + 16'd1;
      busy          = 1'b0;
      done          = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr & 32'hFFFF_FFFC;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               cnt_d   = '0;
               if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            busy  = 1'b1;
            cnt_d = cnt_inc;
            // AW and W complete independently and in any order.
            if (awvalid_q && axilWriteSlave_awready) awvalid_d = 1'b0;
            if (wvalid_q && axilWriteSlave_wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            busy  = 1'b1;
            cnt_d = cnt_inc;
            if (axilWriteSlave_bvalid) begin
               done          = 1'b1;
               bready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               resp_d        = axilWriteSlave_bresp;
               rdata_d       = '0;
               rsp_timeout_d = 1'b0;
               state_d       = RESP;
            end
         end
         RD_REQ: begin
            busy  = 1'b1;
            cnt_d = cnt_inc;
            if (axilReadSlave_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            busy  = 1'b1;
            cnt_d = cnt_inc;
            if (axilReadSlave_rvalid) begin
               done          = 1'b1;
               rready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               resp_d        = axilReadSlave_rresp;
               rdata_d       = axilReadSlave_rdata;
               rsp_timeout_d = 1'b0;
               state_d       = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A final handshake landing on the last allowed cycle still completes normally.
      timeout_hit = busy && !done && (cnt_inc == TIMEOUT_LIMIT);
      if (timeout_hit) begin
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         arvalid_d     = 1'b0;
         bready_d      = 1'b0;
         rready_d      = 1'b0;
         rsp_valid_d   = 1'b1;
         resp_d        = RESP_SLVERR;
         rdata_d       = '0;
         rsp_timeout_d = 1'b1;
         if (tcount_q != 16'hFFFF) tcount_d = tcount_q + 16'd1;
         state_d       = RESP;
      end
   end

   always_ff @(posedge axilClk) begin
      if (axilRst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         tcount_q      <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         rdata_q       <= '0;
         resp_q        <= RESP_OKAY;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         bready_q      <= 1'b0;
         rready_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tcount_q      <= tcount_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         rdata_q       <= rdata_d;
         resp_q        <= resp_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         arvalid_q     <= arvalid_d;
         bready_q      <= bready_d;
         rready_q      <= rready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign cmd_ready               = (state_q == IDLE);
   assign rsp_valid               = rsp_valid_q;
   assign rsp_rdata               = rdata_q;
   assign rsp_resp                = resp_q;
   assign rsp_timeout             = rsp_timeout_q;
   assign timeout_count           = tcount_q;
   assign axilReadMaster_araddr   = addr_q;
   assign axilReadMaster_arprot   = AXI_PROT;
   assign axilReadMaster_arvalid  = arvalid_q;
   assign axilReadMaster_rready   = rready_q;
   assign axilWriteMaster_awaddr  = addr_q;
   assign axilWriteMaster_awprot  = AXI_PROT;
   assign axilWriteMaster_awvalid = awvalid_q;
   assign axilWriteMaster_wdata   = wdata_q;
   assign axilWriteMaster_wstrb   = wstrb_q;
   assign axilWriteMaster_wvalid  = wvalid_q;
   assign axilWriteMaster_bready  = bready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Self-checking bench for axil_cmd_master: a delay-programmable AXI-Lite
// responder plus a queue of expected responses checked per scenario task.
module tb_axil_cmd_master;
   import ldmx_axil_pkg::*;

   logic axilClk = 1'b0;
   logic axilRst;
   always #5 axilClk = ~axilClk;

   axil_cmd_master_if bus();

   axil_cmd_master #(.TIMEOUT_CYCLES(16), .AXI_PROT(3'b101)) dut (
      .axilClk(axilClk), .axilRst(axilRst),
      .cmd_valid(bus.cmd_valid), .cmd_ready(bus.cmd_ready), .cmd_write(bus.cmd_write),
      .cmd_addr(bus.cmd_addr), .cmd_wdata(bus.cmd_wdata), .cmd_wstrb(bus.cmd_wstrb),
      .rsp_valid(bus.rsp_valid), .rsp_ready(bus.rsp_ready), .rsp_rdata(bus.rsp_rdata),
      .rsp_resp(bus.rsp_resp), .rsp_timeout(bus.rsp_timeout), .timeout_count(bus.timeout_count),
      .axilReadMaster_araddr(bus.axilReadMaster_araddr),
      .axilReadMaster_arprot(bus.axilReadMaster_arprot),
      .axilReadMaster_arvalid(bus.axilReadMaster_arvalid),
      .axilReadMaster_rready(bus.axilReadMaster_rready),
      .axilReadSlave_arready(bus.axilReadSlave_arready),
      .axilReadSlave_rdata(bus.axilReadSlave_rdata),
      .axilReadSlave_rresp(bus.axilReadSlave_rresp),
      .axilReadSlave_rvalid(bus.axilReadSlave_rvalid),
      .axilWriteMaster_awaddr(bus.axilWriteMaster_awaddr),
      .axilWriteMaster_awprot(bus.axilWriteMaster_awprot),
      .axilWriteMaster_awvalid(bus.axilWriteMaster_awvalid),
      .axilWriteMaster_wdata(bus.axilWriteMaster_wdata),
      .axilWriteMaster_wstrb(bus.axilWriteMaster_wstrb),
      .axilWriteMaster_wvalid(bus.axilWriteMaster_wvalid),
      .axilWriteMaster_bready(bus.axilWriteMaster_bready),
      .axilWriteSlave_awready(bus.axilWriteSlave_awready),
      .axilWriteSlave_wready(bus.axilWriteSlave_wready),
      .axilWriteSlave_bresp(bus.axilWriteSlave_bresp),
      .axilWriteSlave_bvalid(bus.axilWriteSlave_bvalid)
   );

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        to;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Responder knobs: each delay counts cycles of the matching valid/ready.
   int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
   bit          silent;
   logic [1:0]  b_resp_v, r_resp_v;
   logic [31:0] r_data_v;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   int          aw_hs = 0, w_hs = 0, ar_hs = 0;

   initial begin
      forever begin
         @(negedge axilClk);
         bus.axilWriteSlave_awready = 1'b0;
         bus.axilWriteSlave_wready  = 1'b0;
         bus.axilWriteSlave_bvalid  = 1'b0;
         bus.axilWriteSlave_bresp   = 2'b00;
         bus.axilReadSlave_arready  = 1'b0;
         bus.axilReadSlave_rvalid   = 1'b0;
         bus.axilReadSlave_rresp    = 2'b00;
         bus.axilReadSlave_rdata    = 32'h0;
         if (bus.cmd_ready || axilRst) begin
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
         end
         if (!silent && !axilRst) begin
            if (bus.axilWriteMaster_awvalid) begin
               if (aw_cnt == aw_dly) bus.axilWriteSlave_awready = 1'b1;
               aw_cnt++;
            end
            if (bus.axilWriteMaster_wvalid) begin
               if (w_cnt == w_dly) bus.axilWriteSlave_wready = 1'b1;
               w_cnt++;
            end
            if (bus.axilWriteMaster_bready) begin
               if (b_cnt == b_dly) begin
                  bus.axilWriteSlave_bvalid = 1'b1;
                  bus.axilWriteSlave_bresp  = b_resp_v;
               end
               b_cnt++;
            end
            if (bus.axilReadMaster_arvalid) begin
               if (ar_cnt == ar_dly) bus.axilReadSlave_arready = 1'b1;
               ar_cnt++;
            end
            if (bus.axilReadMaster_rready) begin
               if (r_cnt == r_dly) begin
                  bus.axilReadSlave_rvalid = 1'b1;
                  bus.axilReadSlave_rdata  = r_data_v;
                  bus.axilReadSlave_rresp  = r_resp_v;
               end
               r_cnt++;
            end
         end
         if (bus.axilWriteMaster_awvalid && bus.axilWriteSlave_awready) aw_hs++;
         if (bus.axilWriteMaster_wvalid && bus.axilWriteSlave_wready)   w_hs++;
         if (bus.axilReadMaster_arvalid && bus.axilReadSlave_arready)   ar_hs++;
      end
   end

   task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
      aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
   endtask

   // Called at a negedge with cmd_ready high; returns at the negedge of cycle 1.
   task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_wstrb = s;
      bus.cmd_valid = 1'b1;
      @(negedge axilClk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int budget, output bit seen);
      int n = 0;
      while (!bus.rsp_valid && n < budget) begin
         @(negedge axilClk);
         n++;
      end
      seen = bus.rsp_valid;
   endtask

   task automatic consume();
      bus.rsp_ready = 1'b1;
      @(negedge axilClk);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic pop_exp(output exp_t e);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{32'hx, 2'bx, 1'bx};
   endtask

   task automatic test_reset();
      axilRst = 1'b1; bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
      bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_wstrb = '0;
      silent = 1'b0; set_dly(0, 0, 0, 0, 0);
      b_resp_v = RESP_OKAY; r_resp_v = RESP_OKAY; r_data_v = 32'h0;
      repeat (3) @(negedge axilClk);
      n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
      n_checks++; if ({bus.axilWriteMaster_awvalid, bus.axilWriteMaster_wvalid, bus.axilWriteMaster_bready,
                       bus.axilReadMaster_arvalid, bus.axilReadMaster_rready} !== 5'b0)
         $display("FAIL rst_axi_valids: got %b want 00000", {bus.axilWriteMaster_awvalid, bus.axilWriteMaster_wvalid,
                  bus.axilWriteMaster_bready, bus.axilReadMaster_arvalid, bus.axilReadMaster_rready}); else n_pass++;
      n_checks++; if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_resp} !== 4'b0)
         $display("FAIL rst_rsp: got %b want 0000", {bus.rsp_valid, bus.rsp_timeout, bus.rsp_resp}); else n_pass++;
      n_checks++; if (bus.timeout_count !== 16'h0) $display("FAIL rst_tcount: got %h want 0000", bus.timeout_count); else n_pass++;
      n_checks++; if (bus.axilWriteMaster_awaddr !== 32'h0 || bus.rsp_rdata !== 32'h0)
         $display("FAIL rst_addr_data: got %h/%h want 0/0", bus.axilWriteMaster_awaddr, bus.rsp_rdata); else n_pass++;
      axilRst = 1'b0;
      @(negedge axilClk);
      n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", bus.cmd_ready); else n_pass++;
      $display("test_reset done");
   endtask

   task automatic test_write_zero_wait();
      exp_t e;
      set_dly(0, 0, 0, 0, 0); b_resp_v = RESP_OKAY;
      exp_q.push_back('{32'h0, 2'b00, 1'b0});
      send_cmd(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF);
      n_checks++; if ({bus.axilWriteMaster_awvalid, bus.axilWriteMaster_wvalid} !== 2'b11)
         $display("FAIL wz_valids_c1: got %b want 11", {bus.axilWriteMaster_awvalid, bus.axilWriteMaster_wvalid}); else n_pass++;
      n_checks++; if (bus.axilWriteMaster_awaddr !== 32'h104) $display("FAIL wz_awaddr: got %h want 00000104", bus.axilWriteMaster_awaddr); else n_pass++;
      n_checks++; if (bus.axilWriteMaster_wdata !== 32'hDEAD_BEEF || bus.axilWriteMaster_wstrb !== 4'hF)
         $display("FAIL wz_wdata: got %h/%h want deadbeef/f", bus.axilWriteMaster_wdata, bus.axilWriteMaster_wstrb); else n_pass++;
      n_checks++; if (bus.axilWriteMaster_awprot !== 3'b101) $display("FAIL wz_awprot: got %b want 101", bus.axilWriteMaster_awprot); else n_pass++;
      @(negedge axilClk);
      n_checks++; if ({bus.axilWriteMaster_bready, bus.rsp_valid} !== 2'b10)
         $display("FAIL wz_c2: got bready/rsp_valid %b want 10", {bus.axilWriteMaster_bready, bus.rsp_valid}); else n_pass++;
      @(negedge axilClk);
      n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL wz_rsp_c3: got %b want 1", bus.rsp_valid); else n_pass++;
      pop_exp(e);
      n_checks++; if ({bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout} !== {e.rdata, e.resp, e.to})
         $display("FAIL wz_payload: got %h/%b/%b want %h/%b/%b", bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, e.rdata, e.resp, e.to); else n_pass++;
      consume();
      $display("test_write_zero_wait done");
   endtask

   task automatic test_write_split();
      exp_t e; bit seen; bit extra = 1'b0;
      int aw0 = aw_hs, w0 = w_hs;
      set_dly(3, 0, 4, 0, 0); b_resp_v = RESP_OKAY;
      exp_q.push_back('{32'h0, 2'b00, 1'b0});
      send_cmd(1'b1, 32'h0000_0010, 32'h0BAD_F00D, 4'h3);
      @(negedge axilClk);
      n_checks++; if ({bus.axilWriteMaster_awvalid, bus.axilWriteMaster_wvalid} !== 2'b10)
         $display("FAIL ws_w_dropped_c2: got %b want 10", {bus.axilWriteMaster_awvalid, bus.axilWriteMaster_wvalid}); else n_pass++;
      repeat (3) @(negedge axilClk);
      n_checks++; if ({bus.axilWriteMaster_awvalid, bus.axilWriteMaster_wvalid, bus.axilWriteMaster_bready} !== 3'b001)
         $display("FAIL ws_aw_dropped_c5: got %b want 001", {bus.axilWriteMaster_awvalid, bus.axilWriteMaster_wvalid,
                  bus.axilWriteMaster_bready}); else n_pass++;
      wait_rsp(30, seen);
      n_checks++; if (seen !== 1'b1) $display("FAIL ws_rsp_seen: got %b want 1", seen); else n_pass++;
      pop_exp(e);
      n_checks++; if ({bus.rsp_resp, bus.rsp_timeout} !== {e.resp, e.to})
         $display("FAIL ws_resp: got %b/%b want %b/%b", bus.rsp_resp, bus.rsp_timeout, e.resp, e.to); else n_pass++;
      consume();
      repeat (4) begin
         if (bus.rsp_valid) extra = 1'b1;
         @(negedge axilClk);
      end
      n_checks++; if (extra !== 1'b0) $display("FAIL ws_single_rsp: got extra=%b want 0", extra); else n_pass++;
      n_checks++; if (aw_hs - aw0 != 1 || w_hs - w0 != 1)
         $display("FAIL ws_beats: got aw=%0d w=%0d want 1/1", aw_hs - aw0, w_hs - w0); else n_pass++;
      $display("test_write_split done");
   endtask

   task automatic test_read_delayed();
      exp_t e; bit seen;
      int ar0 = ar_hs;
      set_dly(0, 0, 0, 2, 0); r_data_v = 32'h1234_5678; r_resp_v = RESP_OKAY;
      exp_q.push_back('{32'h1234_5678, 2'b00, 1'b0});
      send_cmd(1'b0, 32'h0000_0208, 32'h0, 4'h0);
      n_checks++; if (bus.axilReadMaster_arvalid !== 1'b1 || bus.axilReadMaster_araddr !== 32'h208)
         $display("FAIL rd_ar_c1: got %b/%h want 1/00000208", bus.axilReadMaster_arvalid, bus.axilReadMaster_araddr); else n_pass++;
      wait_rsp(30, seen);
      n_checks++; if (seen !== 1'b1) $display("FAIL rd_rsp_seen: got %b want 1", seen); else n_pass++;
      pop_exp(e);
      n_checks++; if ({bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout} !== {e.rdata, e.resp, e.to})
         $display("FAIL rd_payload: got %h/%b/%b want %h/%b/%b", bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, e.rdata, e.resp, e.to); else n_pass++;
      consume();
      repeat (3) @(negedge axilClk);
      n_checks++; if (ar_hs - ar0 != 1) $display("FAIL rd_ar_beats: got %0d want 1", ar_hs - ar0); else n_pass++;
      $display("test_read_delayed done");
   endtask

   task automatic test_timeout();
      exp_t e; bit seen; int hi = 0;
      silent = 1'b1;
      exp_q.push_back('{32'h0, 2'b10, 1'b1});
      send_cmd(1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'hF);
      while (bus.axilWriteMaster_awvalid && hi < 40) begin
         hi++;
         @(negedge axilClk);
      end
      n_checks++; if (hi != 16) $display("FAIL to_valid_cycles: got %0d want 16", hi); else n_pass++;
      n_checks++; if ({bus.axilWriteMaster_wvalid, bus.axilWriteMaster_bready, bus.rsp_valid} !== 3'b001)
         $display("FAIL to_drop: got wvalid/bready/rsp_valid %b want 001", {bus.axilWriteMaster_wvalid,
                  bus.axilWriteMaster_bready, bus.rsp_valid}); else n_pass++;
      pop_exp(e);
      n_checks++; if ({bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout} !== {e.rdata, e.resp, e.to})
         $display("FAIL to_payload: got %h/%b/%b want %h/%b/%b", bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, e.rdata, e.resp, e.to); else n_pass++;
      n_checks++; if (bus.timeout_count !== 16'd1) $display("FAIL to_count: got %0d want 1", bus.timeout_count); else n_pass++;
      consume();
      silent = 1'b0;
      set_dly(0, 0, 0, 0, 0); r_data_v = 32'h0000_00C3; r_resp_v = RESP_OKAY;
      n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL to_next_ready: got %b want 1", bus.cmd_ready); else n_pass++;
      exp_q.push_back('{32'h0000_00C3, 2'b00, 1'b0});
      send_cmd(1'b0, 32'h0000_0050, 32'h0, 4'h0);
      wait_rsp(30, seen);
      pop_exp(e);
      n_checks++; if (!seen || {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout} !== {e.rdata, e.resp, e.to})
         $display("FAIL to_next_cmd: got %b %h/%b/%b want 1 %h/%b/%b", seen, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, e.rdata, e.resp, e.to); else n_pass++;
      consume();
      $display("test_timeout done");
   endtask

   task automatic test_timeout_boundary();
      exp_t e; bit seen;
      // rvalid on the 16th cycle: completion and timeout coincide.
      set_dly(0, 0, 0, 0, 14); r_data_v = 32'hCAFE_0001; r_resp_v = RESP_OKAY;
      exp_q.push_back('{32'hCAFE_0001, 2'b00, 1'b0});
      send_cmd(1'b0, 32'h0000_0060, 32'h0, 4'h0);
      wait_rsp(40, seen);
      pop_exp(e);
      n_checks++; if (!seen || {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout} !== {e.rdata, e.resp, e.to})
         $display("FAIL tb_edge_wins: got %b %h/%b/%b want 1 %h/%b/%b", seen, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, e.rdata, e.resp, e.to); else n_pass++;
      n_checks++; if (bus.timeout_count !== 16'd1) $display("FAIL tb_edge_count: got %0d want 1", bus.timeout_count); else n_pass++;
      consume();
      // One cycle later the bus has already been abandoned.
      set_dly(0, 0, 0, 0, 15);
      exp_q.push_back('{32'h0, 2'b10, 1'b1});
      send_cmd(1'b0, 32'h0000_0064, 32'h0, 4'h0);
      wait_rsp(40, seen);
      pop_exp(e);
      n_checks++; if (!seen || {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout} !== {e.rdata, e.resp, e.to})
         $display("FAIL tb_late_timeout: got %b %h/%b/%b want 1 %h/%b/%b", seen, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, e.rdata, e.resp, e.to); else n_pass++;
      n_checks++; if (bus.timeout_count !== 16'd2) $display("FAIL tb_late_count: got %0d want 2", bus.timeout_count); else n_pass++;
      consume();
      $display("test_timeout_boundary done");
   endtask

   task automatic test_rsp_stall();
      exp_t e; bit seen; bit stable = 1'b1;
      set_dly(0, 0, 0, 0, 0); r_data_v = 32'hA5A5_0F0F; r_resp_v = RESP_SLVERR;
      exp_q.push_back('{32'hA5A5_0F0F, 2'b10, 1'b0});
      send_cmd(1'b0, 32'h0000_0070, 32'h0, 4'h0);
      wait_rsp(30, seen);
      pop_exp(e);
      n_checks++; if (!seen || {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout} !== {e.rdata, e.resp, e.to})
         $display("FAIL st_payload: got %b %h/%b/%b want 1 %h/%b/%b", seen, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, e.rdata, e.resp, e.to); else n_pass++;
      repeat (10) begin
         @(negedge axilClk);
         if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 ||
             {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout} !== {e.rdata, e.resp, e.to}) stable = 1'b0;
      end
      n_checks++; if (stable !== 1'b1) $display("FAIL st_stable: got %b want 1", stable); else n_pass++;
      b_resp_v = RESP_OKAY;
      bus.cmd_write = 1'b1; bus.cmd_addr = 32'h0000_0080; bus.cmd_wdata = 32'h0000_0001; bus.cmd_wstrb = 4'h1;
      bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b1;
      n_checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL st_ready_during_pulse: got %b want 0", bus.cmd_ready); else n_pass++;
      @(negedge axilClk);
      bus.rsp_ready = 1'b0;
      n_checks++; if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10)
         $display("FAIL st_ready_after_pulse: got cmd_ready/rsp_valid %b want 10", {bus.cmd_ready, bus.rsp_valid}); else n_pass++;
      exp_q.push_back('{32'h0, 2'b00, 1'b0});
      @(negedge axilClk);
      bus.cmd_valid = 1'b0;
      n_checks++; if ({bus.axilWriteMaster_awvalid, bus.cmd_ready} !== 2'b10)
         $display("FAIL st_next_accept: got awvalid/cmd_ready %b want 10", {bus.axilWriteMaster_awvalid, bus.cmd_ready}); else n_pass++;
      wait_rsp(30, seen);
      pop_exp(e);
      n_checks++; if (!seen || {bus.rsp_resp, bus.rsp_timeout} !== {e.resp, e.to})
         $display("FAIL st_next_rsp: got %b %b/%b want 1 %b/%b", seen, bus.rsp_resp, bus.rsp_timeout, e.resp, e.to); else n_pass++;
      consume();
      $display("test_rsp_stall done");
   endtask

   task automatic test_back_to_back();
      exp_t e; int acc = 0; int got = 0; int acc_cyc[2] = '{0, 0}; bit load_next = 1'b0;
      set_dly(0, 0, 0, 0, 0); b_resp_v = RESP_DECERR; r_data_v = 32'h7777_8888; r_resp_v = RESP_OKAY;
      bus.cmd_write = 1'b1; bus.cmd_addr = 32'h0000_0033; bus.cmd_wdata = 32'h1111_2222; bus.cmd_wstrb = 4'hF;
      bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 24; cyc++) begin
         if (load_next) begin
            load_next = 1'b0;
            if (acc == 1) begin
               bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0000_0044;
            end else bus.cmd_valid = 1'b0;
         end
         if (bus.cmd_valid && bus.cmd_ready && acc < 2) begin
            acc_cyc[acc] = cyc;
            acc++;
            if (acc == 1) exp_q.push_back('{32'h0, 2'b11, 1'b0});
            else exp_q.push_back('{32'h7777_8888, 2'b00, 1'b0});
            load_next = 1'b1;
         end
         if (acc == 1 && cyc == acc_cyc[0] + 1) begin
            n_checks++; if (bus.axilWriteMaster_awvalid !== 1'b1 || bus.axilWriteMaster_awaddr !== 32'h30)
               $display("FAIL bb_awaddr_align: got %b/%h want 1/00000030", bus.axilWriteMaster_awvalid, bus.axilWriteMaster_awaddr); else n_pass++;
         end
         if (bus.rsp_valid) begin
            pop_exp(e);
            got++;
            n_checks++; if ({bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout} !== {e.rdata, e.resp, e.to})
               $display("FAIL bb_payload%0d: got %h/%b/%b want %h/%b/%b", got, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, e.rdata, e.resp, e.to); else n_pass++;
         end
         @(negedge axilClk);
      end
      bus.rsp_ready = 1'b0;
      n_checks++; if (acc != 2 || got != 2) $display("FAIL bb_counts: got acc=%0d rsp=%0d want 2/2", acc, got); else n_pass++;
      n_checks++; if (acc_cyc[1] - acc_cyc[0] != 4) $display("FAIL bb_spacing: got %0d want 4", acc_cyc[1] - acc_cyc[0]); else n_pass++;
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid();
      bit quiet = 1'b1;
      set_dly(0, 0, 0, 0, 20); r_data_v = 32'hBAD0_BAD0;
      send_cmd(1'b0, 32'h0000_0300, 32'h0, 4'h0);
      @(negedge axilClk);
      n_checks++; if (bus.axilReadMaster_rready !== 1'b1) $display("FAIL rm_in_rd_data: got rready %b want 1", bus.axilReadMaster_rready); else n_pass++;
      axilRst = 1'b1;
      @(negedge axilClk);
      n_checks++; if ({bus.axilReadMaster_rready, bus.axilReadMaster_arvalid, bus.rsp_valid} !== 3'b000)
         $display("FAIL rm_outputs: got rready/arvalid/rsp_valid %b want 000", {bus.axilReadMaster_rready,
                  bus.axilReadMaster_arvalid, bus.rsp_valid}); else n_pass++;
      n_checks++; if (bus.axilReadMaster_araddr !== 32'h0 || bus.timeout_count !== 16'h0)
         $display("FAIL rm_regs: got araddr %h tcount %0d want 0/0", bus.axilReadMaster_araddr, bus.timeout_count); else n_pass++;
      axilRst = 1'b0;
      repeat (6) begin
         @(negedge axilClk);
         if (bus.rsp_valid !== 1'b0) quiet = 1'b0;
      end
      n_checks++; if (quiet !== 1'b1) $display("FAIL rm_no_rsp: got quiet=%b want 1", quiet); else n_pass++;
      n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rm_ready: got %b want 1", bus.cmd_ready); else n_pass++;
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_write_split();
      test_read_delayed();
      test_timeout();
      test_timeout_boundary();
      test_rsp_stall();
      test_back_to_back();
      test_reset_mid();
      n_checks++; if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
